// File: rtl/can_tx_scheduler_if.sv
// Bus bundle between a CAN host (master side) and can_tx_scheduler (slave side).
// Groups bit-timing inputs, mailbox requests, transmitter pulses and scheduler outputs.
interface can_tx_scheduler_if;
  logic        sample;
  logic        rx_bit;
  logic [3:0]  req;
  logic [43:0] id_flat;
  logic        tx_done;
  logic        tx_arb_lost;
  logic        tx_error;
  logic        tx_start;
  logic [10:0] tx_id;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [3:0]  abort;
  logic        bus_idle;
  logic [1:0]  debug_state;

  modport master (
    output sample, rx_bit, req, id_flat, tx_done, tx_arb_lost, tx_error,
    input  tx_start, tx_id, grant, done, abort, bus_idle, debug_state
  );

  modport slave (
    input  sample, rx_bit, req, id_flat, tx_done, tx_arb_lost, tx_error,
    output tx_start, tx_id, grant, done, abort, bus_idle, debug_state
  );
endinterface

// File: rtl/can_tx_scheduler.sv
// Four-mailbox CAN transmit scheduler: bus-idle detection, lowest-ID arbitration, frame outcome.
// Define CAN_TX_RETRY_LIMIT_EN to abort a mailbox after 16 error retries (otherwise unlimited).
module can_tx_scheduler (
  input logic              clk,
  input logic              rst_n,
  can_tx_scheduler_if.slave bus
);

  localparam logic [1:0] S_SYNC  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_TX    = 2'd3;

  localparam logic [3:0] NEED_FULL  = 4'd11;
  localparam logic [3:0] NEED_INTER = 4'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  idle_cnt_q, idle_cnt_d;
  logic [3:0]  idle_need_q, idle_need_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  done_q, done_d;
  logic [10:0] tx_id_q, tx_id_d;
  logic        tx_start_q;
  logic [3:0]  eligible;
  logic [3:0]  win_oh;
  logic [10:0] win_id;
  logic        foreign_sof;

`ifdef CAN_TX_RETRY_LIMIT_EN
  logic [4:0] retry_q [4];
  logic [4:0] retry_d [4];
  logic [3:0] blocked_q, blocked_d;
  logic [3:0] abort_q, abort_d;

  assign eligible = bus.req & ~blocked_q;
`else
  assign eligible = bus.req;
`endif

  assign foreign_sof = bus.sample & ~bus.rx_bit;

  // Strict '<' keeps the first (lowest-index) mailbox on equal IDs.
  always_comb begin
    win_oh = 4'b0000;
    win_id = 11'h7FF;
    for (int n = 0; n < 4; n++) begin
      if (eligible[n] && (win_oh == 4'b0000 || bus.id_flat[11*n +: 11] < win_id)) begin
        win_oh = 4'b0001 << n;
        win_id = bus.id_flat[11*n +: 11];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    idle_need_d = idle_need_q;
    grant_d     = grant_q;
    tx_id_d     = tx_id_q;
    done_d      = 4'b0000;
`ifdef CAN_TX_RETRY_LIMIT_EN
    retry_d   = retry_q;
    blocked_d = blocked_q & bus.req;
    abort_d   = 4'b0000;
`endif
    case (state_q)
      S_SYNC: begin
        if (bus.sample) begin
          if (!bus.rx_bit) begin
            idle_cnt_d = 4'd0;
          end else if (idle_cnt_q != 4'hF) begin
            idle_cnt_d = idle_cnt_q + 4'd1;
          end
          if (idle_cnt_d >= idle_need_q) begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (foreign_sof) begin
          state_d     = S_SYNC;
          idle_cnt_d  = 4'd0;
          idle_need_d = NEED_FULL;
        end else if (eligible != 4'b0000) begin
          grant_d = win_oh;
          tx_id_d = win_id;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_TX;
      end
      default: begin
        // Coinciding transmitter pulses resolve as error, then arbitration loss, then done.
        if (bus.tx_error || bus.tx_arb_lost || bus.tx_done) begin
          state_d     = S_SYNC;
          idle_cnt_d  = 4'd0;
          grant_d     = 4'b0000;
          idle_need_d = NEED_FULL;
          if (bus.tx_error) begin
`ifdef CAN_TX_RETRY_LIMIT_EN
            for (int n = 0; n < 4; n++) begin
              if (grant_q[n]) begin
                if (retry_q[n] == 5'd15) begin
                  retry_d[n]   = 5'd0;
                  abort_d[n]   = 1'b1;
                  blocked_d[n] = 1'b1;
                end else if (retry_q[n] != 5'd31) begin
                  retry_d[n] = retry_q[n] + 5'd1;
                end
              end
            end
`endif
          end else if (!bus.tx_arb_lost) begin
            done_d      = grant_q;
            idle_need_d = NEED_INTER;
`ifdef CAN_TX_RETRY_LIMIT_EN
            for (int n = 0; n < 4; n++) begin
              if (grant_q[n]) retry_d[n] = 5'd0;
            end
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      idle_cnt_q  <= 4'd0;
      idle_need_q <= NEED_FULL;
      grant_q     <= 4'b0000;
      done_q      <= 4'b0000;
      tx_id_q     <= 11'd0;
      tx_start_q  <= 1'b0;
`ifdef CAN_TX_RETRY_LIMIT_EN
      retry_q   <= '{default: 5'd0};
      blocked_q <= 4'b0000;
      abort_q   <= 4'b0000;
`endif
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      idle_need_q <= idle_need_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      tx_id_q     <= tx_id_d;
      tx_start_q  <= (state_q == S_START);
`ifdef CAN_TX_RETRY_LIMIT_EN
      retry_q   <= retry_d;
      blocked_q <= blocked_d;
      abort_q   <= abort_d;
`endif
    end
  end

  assign bus.tx_start    = tx_start_q;
  assign bus.tx_id       = tx_id_q;
  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.bus_idle    = (state_q == S_IDLE);
  assign bus.debug_state = state_q;
`ifdef CAN_TX_RETRY_LIMIT_EN
  assign bus.abort = abort_q;
`else
  assign bus.abort = 4'b0000;
`endif

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Randomized scoreboard bench for can_tx_scheduler; a transaction-level model predicts
// tx_start/done/abort events with their clock edge, and a monitor pops and compares them.
`timescale 1ns/1ps
module tb_can_tx_scheduler;

  localparam int KIND_START = 0;
  localparam int KIND_DONE  = 1;
  localparam int KIND_ABORT = 2;
  localparam int NITER      = 120;

  typedef struct {
    int          kind;
    int          cyc;
    logic [10:0] id;
    logic [3:0]  mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t expQ[$];

  logic [3:0]  reqM;
  logic [3:0]  blockedM;
  logic [10:0] idM [4];
  int          retryM [4];
  int          needM;
  bit          resetDone = 1'b0;

  can_tx_scheduler_if bus ();

  can_tx_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void pushExp(input int kind, input int c, input logic [10:0] id, input logic [3:0] mask);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.id   = id;
    e.mask = mask;
    expQ.push_back(e);
  endfunction

  task automatic checkEvent(input int kind);
    exp_t e;
    if (expQ.size() == 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("[TB] FAIL unexpected_event: got kind %0d, expected no event (cycle %0d)", kind, cyc);
    end else begin
      e = expQ.pop_front();
      checkOutput("event_kind", kind, e.kind);
      checkOutput("event_cycle", cyc, e.cyc);
      if (kind == KIND_START) begin
        checkOutput("tx_id", {21'd0, bus.tx_id}, {21'd0, e.id});
        checkOutput("grant", {28'd0, bus.grant}, {28'd0, e.mask});
      end else if (kind == KIND_DONE) begin
        checkOutput("done", {28'd0, bus.done}, {28'd0, e.mask});
        checkOutput("grant_after_done", {28'd0, bus.grant}, 32'd0);
      end else begin
        checkOutput("abort", {28'd0, bus.abort}, {28'd0, e.mask});
      end
    end
  endtask

  // Monitor: compares every presented output against the queue head and flags missed events.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (bus.tx_start === 1'b1) checkEvent(KIND_START);
      if (bus.done !== 4'b0000) checkEvent(KIND_DONE);
      if (bus.abort !== 4'b0000) checkEvent(KIND_ABORT);
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        total = total + 1;
        bad = bad + 1;
        $display("[TB] FAIL missed_event: got nothing, expected kind %0d at cycle %0d (now %0d)",
                 expQ[0].kind, expQ[0].cyc, cyc);
        void'(expQ.pop_front());
      end
    end
  end

  function automatic logic [10:0] pickId();
    case ($urandom_range(0, 5))
      0: return 11'h100;
      1: return 11'h200;
      2: return 11'h123;
      3: return 11'h7FF;
      default: return 11'($urandom_range(0, 2047));
    endcase
  endfunction

  task automatic quiet();
    bus.sample      = 1'b0;
    bus.rx_bit      = 1'($urandom_range(0, 1));
    bus.tx_done     = 1'b0;
    bus.tx_arb_lost = 1'b0;
    bus.tx_error    = 1'b0;
  endtask

  task automatic strayPulse();
    case ($urandom_range(0, 2))
      0: bus.tx_done = 1'b1;
      1: bus.tx_arb_lost = 1'b1;
      default: bus.tx_error = 1'b1;
    endcase
  endtask

  task automatic syncReq();
    bus.req     = reqM;
    bus.id_flat = {idM[3], idM[2], idM[1], idM[0]};
  endtask

  // Feeds samples until the model's run of recessive bits meets the current idle requirement.
  task automatic runSync(output int idleEdge);
    int run;
    bit rx;
    run = 0;
    idleEdge = 0;
    while (idleEdge == 0) begin
      @(negedge clk);
      quiet();
      if ($urandom_range(0, 7) == 0) strayPulse();
      if ($urandom_range(0, 2) != 0) begin
        rx = ($urandom_range(0, 9) != 0);
        bus.sample = 1'b1;
        bus.rx_bit = rx;
        run = rx ? ((run == 15) ? 15 : run + 1) : 0;
        if (run >= needM) idleEdge = cyc + 1;
      end
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic applyStimulus(input int iter);
    int          t;
    int          gi;
    int          p;
    int          bestKey;
    logic [3:0]  elig;
    logic [3:0]  g;
    logic [2:0]  outcome;

    @(negedge clk);
    quiet();
    for (int n = 0; n < 4; n++) begin
      if (!reqM[n] && $urandom_range(0, 1) == 1) begin
        idM[n]  = pickId();
        reqM[n] = 1'b1;
      end
    end
    syncReq();

    runSync(t);
    elig = reqM & ~blockedM;

    if (elig == 4'b0000) begin
      repeat ($urandom_range(1, 3)) begin
        checkOutput("idle_bus_idle", {31'd0, bus.bus_idle}, 32'd1);
        checkOutput("idle_state", {30'd0, bus.debug_state}, 32'd1);
        @(negedge clk);
        quiet();
        if ($urandom_range(0, 3) == 0) strayPulse();
      end
      @(negedge clk);
      quiet();
      reqM = 4'b0000;
      blockedM = 4'b0000;
      syncReq();
      @(negedge clk);
      quiet();
      for (int n = 0; n < 4; n++) idM[n] = pickId();
      reqM = 4'($urandom_range(1, 15));
      syncReq();
      bus.sample = 1'b1;
      bus.rx_bit = 1'b0;
      @(negedge clk);
      quiet();
      checkOutput("sof_state", {30'd0, bus.debug_state}, 32'd0);
      checkOutput("sof_bus_idle", {31'd0, bus.bus_idle}, 32'd0);
      needM = 11;
    end else begin
      // Winner = smallest (id, index) pair among eligible mailboxes.
      gi = 0;
      bestKey = 32'h7FFF_FFFF;
      for (int n = 0; n < 4; n++) begin
        if (elig[n] && (int'(idM[n]) * 4 + n) < bestKey) begin
          bestKey = int'(idM[n]) * 4 + n;
          gi = n;
        end
      end
      g = 4'b0001 << gi;
      pushExp(KIND_START, t + 2, idM[gi], g);

      @(negedge clk);
      quiet();
      if ($urandom_range(0, 3) == 0) strayPulse();
      @(negedge clk);
      quiet();
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 3) == 0) bus.sample = 1'b1;
        if ($urandom_range(0, 5) == 0) begin
          reqM[gi] = 1'b0;
          blockedM[gi] = 1'b0;
          syncReq();
        end
        @(negedge clk);
        quiet();
      end

      if (iter >= NITER / 2 && !resetDone) begin
        resetDone = 1'b1;
        #2;
        rst_n = 1'b0;
        bus.tx_done = 1'b1;
        @(negedge clk);
        checkOutput("rst_tx_grant", {28'd0, bus.grant}, 32'd0);
        checkOutput("rst_tx_done", {28'd0, bus.done}, 32'd0);
        checkOutput("rst_tx_state", {30'd0, bus.debug_state}, 32'd0);
        checkOutput("rst_tx_id", {21'd0, bus.tx_id}, 32'd0);
        quiet();
        @(negedge clk);
        rst_n = 1'b1;
        needM = 11;
        blockedM = 4'b0000;
        for (int n = 0; n < 4; n++) retryM[n] = 0;
      end else begin
        outcome = 3'($urandom_range(1, 7));
        bus.tx_error    = outcome[2];
        bus.tx_arb_lost = outcome[1];
        bus.tx_done     = outcome[0];
        p = cyc + 1;
        if (outcome[2]) begin
          needM = 11;
          if (retryM[gi] < 31) retryM[gi] = retryM[gi] + 1;
`ifdef CAN_TX_RETRY_LIMIT_EN
          if (retryM[gi] == 16) begin
            pushExp(KIND_ABORT, p, 11'd0, g);
            retryM[gi] = 0;
            blockedM[gi] = reqM[gi];
          end
`endif
        end else if (outcome[1]) begin
          needM = 11;
        end else begin
          needM = 3;
          retryM[gi] = 0;
          pushExp(KIND_DONE, p, 11'd0, g);
        end
        @(negedge clk);
        quiet();
        if (outcome == 3'b001 || ($urandom_range(0, 1) == 1 && outcome[2] && retryM[gi] == 0)) begin
          reqM[gi] = 1'b0;
          blockedM[gi] = 1'b0;
          syncReq();
        end
      end
    end
  endtask

  initial begin
    quiet();
    reqM = 4'b0000;
    blockedM = 4'b0000;
    needM = 11;
    for (int n = 0; n < 4; n++) begin
      idM[n] = 11'd0;
      retryM[n] = 0;
    end
    syncReq();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx_start", {31'd0, bus.tx_start}, 32'd0);
    checkOutput("reset_tx_id", {21'd0, bus.tx_id}, 32'd0);
    checkOutput("reset_grant", {28'd0, bus.grant}, 32'd0);
    checkOutput("reset_done", {28'd0, bus.done}, 32'd0);
    checkOutput("reset_abort", {28'd0, bus.abort}, 32'd0);
    checkOutput("reset_bus_idle", {31'd0, bus.bus_idle}, 32'd0);
    checkOutput("reset_state", {30'd0, bus.debug_state}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NITER; i++) applyStimulus(i);

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
